// File: rtl/t1_pack.sv
// t1_pack: packs 10-bit t1 coefficients little-endian into a 32-bit word stream.
// Coefficient i occupies stream bits 10i..10i+9; bit 0 of o_data is the
// earliest stream bit. One polynomial is N_COEFF coefficients, 10*N_COEFF/32 words.
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - synchronous active-high reset
//   i_valid    - coefficient valid
//   i_t1       - 10-bit unsigned coefficient
//   o_ready    - block can accept a coefficient this cycle (registered state only)
//   o_valid    - o_data holds a complete packed word
//   o_data     - packed word
//   o_last     - final word of the polynomial (qualifies o_valid)
//   i_ready    - downstream accepts the word
//   o_overflow - sticky: a coefficient arrived while o_ready was low
module t1_pack #(
  parameter int N_COEFF = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [9:0]  i_t1,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_last,
  input  logic        i_ready,
  output logic        o_overflow
);

  localparam int N_WORDS = 10 * N_COEFF / 32;
  localparam int CW      = $clog2(N_COEFF);
  localparam int WW      = $clog2(N_WORDS);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [63:0]   acc_q, acc_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          ovf_q;

  logic          push, pop;
  logic [63:0]   base;
  logic [6:0]    pos;

  assign o_ready    = (state_q == FILL) && (cnt_q <= 7'd54);
  assign o_valid    = (cnt_q >= 7'd32);
  assign o_data     = acc_q[31:0];
  assign o_last     = o_valid && (wcnt_q == WW'(N_WORDS - 1));
  assign o_overflow = ovf_q;

  assign push = i_valid & o_ready;
  assign pop  = o_valid & i_ready;

  // A pop retires the low word before the new coefficient is merged, so the
  // insert position is measured after the shift.
  always_comb begin
    base = pop ? {32'd0, acc_q[63:32]} : acc_q;
    pos  = cnt_q - (pop ? 7'd32 : 7'd0);
    acc_d = base;
    cnt_d = pos;
    if (push) begin
      acc_d = base | ({54'd0, i_t1} << pos);
      cnt_d = pos + 7'd10;
    end
  end

  always_comb begin
    state_d = state_q;
    ccnt_d  = ccnt_q;
    wcnt_d  = wcnt_q;
    if (push) begin
      if (ccnt_q == CW'(N_COEFF - 1)) begin
        ccnt_d  = '0;
        state_d = DRAIN;
      end else begin
        ccnt_d = ccnt_q + 1'b1;
      end
    end
    // The final pop leaves cnt at zero because the polynomial is word-aligned,
    // so the next polynomial starts with an empty accumulator.
    if (pop) begin
      if (o_last) begin
        wcnt_d  = '0;
        state_d = FILL;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      acc_q   <= '0;
      cnt_q   <= '0;
      ccnt_q  <= '0;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ccnt_q  <= ccnt_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_q | (i_valid & ~o_ready);
    end
  end

endmodule

// File: tb/tb_t1_pack.sv
// Testbench for t1_pack: directed polynomials, golden bit-indexed SimpleBitPack model.
module tb_t1_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [9:0]  i_t1;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_last;
  logic        i_ready;
  logic        o_overflow;

  t1_pack #(.N_COEFF(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_t1       (i_t1),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_last     (o_last),
    .i_ready    (i_ready),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0]  coefs [512];
  logic [31:0] got_w [160];
  logic        got_l [160];
  int          nwords;
  int          rdy_low_cnt;
  logic        probe_rdy;
  int          probe_sent;
  logic [31:0] probe_data;
  logic        probe_vld;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Golden model: each stream bit looked up directly from its coefficient.
  function automatic logic [31:0] gold_word(input int w);
    logic [31:0] r;
    int b;
    for (int k = 0; k < 32; k++) begin
      b = 32 * w + k;
      r[k] = coefs[b / 10][b % 10];
    end
    return r;
  endfunction

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic run(input int n_coef, input int stall_cyc, input int drop_at, input int max_cyc);
    int sent = 0;
    int cyc  = 0;
    int n_exp = n_coef * 10 / 32;
    nwords = 0;
    rdy_low_cnt = 0;
    while (nwords < n_exp && cyc < max_cyc) begin
      i_ready = (cyc >= stall_cyc);
      if (!o_ready) rdy_low_cnt++;
      if (cyc == 6) begin
        probe_rdy  = o_ready;
        probe_sent = sent;
      end
      if (cyc == stall_cyc - 1) begin
        probe_data = o_data;
        probe_vld  = o_valid;
      end
      if (o_valid && i_ready) begin
        got_w[nwords] = o_data;
        got_l[nwords] = o_last;
        nwords++;
      end
      if (sent < n_coef && o_ready) begin
        i_valid = 1'b1;
        i_t1    = coefs[sent];
        sent++;
      end else if (cyc == drop_at) begin
        i_valid = 1'b1;
        i_t1    = 10'h155;
      end else begin
        i_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    check("word_count", 64'(nwords), 64'(n_exp));
  endtask

  task automatic cmp_words(input string tag, input int n);
    for (int w = 0; w < n; w++) begin
      check({tag, "_data"}, 64'(got_w[w]), 64'(gold_word(w)));
      check({tag, "_last"}, 64'(got_l[w]), 64'((w % 80) == 79));
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_t1    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_last", 64'(o_last), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_ovf", 64'(o_overflow), 64'd0);

    // All-ones polynomial, no backpressure.
    for (int i = 0; i < 256; i++) coefs[i] = 10'h3FF;
    run(256, 0, -1, 2000);
    for (int w = 0; w < 80; w++) begin
      check("ones_data", 64'(got_w[w]), 64'hFFFF_FFFF);
      check("ones_last", 64'(got_l[w]), 64'(w == 79));
    end
    check("ones_rdy_low", 64'(rdy_low_cnt), 64'd1);
    check("ones_rdy_back", 64'(o_ready), 64'd1);

    // Ramp polynomial, no backpressure.
    for (int i = 0; i < 256; i++) coefs[i] = 10'(i);
    run(256, 0, -1, 2000);
    check("ramp_w0", 64'(got_w[0]), 64'hC020_0400);
    check("ramp_w1", 64'(got_w[1]), 64'h6014_0400);
    cmp_words("ramp", 80);

    // Ramp with downstream stalled for 20 cycles.
    run(256, 20, -1, 2000);
    check("stall_rdy6", 64'(probe_rdy), 64'd0);
    check("stall_sent6", 64'(probe_sent), 64'd6);
    check("stall_vld", 64'(probe_vld), 64'd1);
    check("stall_data", 64'(probe_data), 64'hC020_0400);
    check("stall_ovf", 64'(o_overflow), 64'd0);
    cmp_words("stall", 80);

    // Stalled with an illegal push injected while o_ready is low.
    run(256, 20, 10, 2000);
    check("drop_ovf", 64'(o_overflow), 64'd1);
    cmp_words("drop", 80);
    run(256, 0, -1, 2000);
    check("drop_ovf_sticky", 64'(o_overflow), 64'd1);
    do_reset();
    check("ovf_cleared", 64'(o_overflow), 64'd0);

    // Two back-to-back polynomials.
    for (int i = 0; i < 256; i++) coefs[i] = 10'(i);
    for (int i = 256; i < 512; i++) coefs[i] = 10'((i * 7 + 3) % 1024);
    run(512, 0, -1, 4000);
    cmp_words("two", 160);

    // Reset mid-polynomial, then a fresh polynomial.
    for (int i = 0; i < 256; i++) coefs[i] = 10'h2AA;
    run(100, 0, -1, 2000);
    do_reset();
    check("mid_rst_valid", 64'(o_valid), 64'd0);
    check("mid_rst_ready", 64'(o_ready), 64'd1);
    for (int i = 0; i < 256; i++) coefs[i] = 10'((i * 13 + 5) % 1024);
    run(256, 0, -1, 2000);
    cmp_words("fresh", 80);
    check("fresh_ovf", 64'(o_overflow), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
